conv_symbol_framer: RTL and testbench
=====================================

Name: conv_symbol_framer

Overview:
- Sits directly downstream of the serial bit capture stage, ahead of the Viterbi decoder input.
- Hunts the received serial code-bit stream for a SYNC_LEN-bit sync word, tolerating up to MAX_ERR bit errors.
- After sync, groups the following bits into WIDTH-bit code symbols with a valid strobe.
- Emits FRAME_SYMS symbols per frame, then re-hunts.

Parameters:
WIDTH, 2, code symbol width in bits (code rate 1/WIDTH); must be >= 2
SYNC_LEN, 8, sync word length in bits; must be >= 2
SYNC_WORD, 8'hB8, sync pattern; MSB is the first bit received
FRAME_SYMS, 16, symbols emitted per frame after sync; must be >= 1
MAX_ERR, 0, maximum Hamming distance accepted as a sync hit; must be < SYNC_LEN

Ports:
clk_sig  input  1  clock; all logic on the rising edge
reset_sig  input  1  asynchronous, active-high reset
serial_sig  input  1  received code bit
bit_en_sig  input  1  serial_sig is valid this cycle
flush_sig  input  1  synchronous abort; return to HUNT
symbol_sig  output  WIDTH  aligned code symbol; first-received bit at MSB
symbol_valid_sig  output  1  one-cycle strobe; symbol_sig is valid
frame_start_sig  output  1  asserted with symbol_valid for symbol index 0
frame_end_sig  output  1  asserted with symbol_valid for symbol index FRAME_SYMS-1
sync_hit_sig  output  1  one-cycle pulse on sync detection
locked_sig  output  1  high while in LOCK

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to HUNT.
  - Sync shift register, fill counter, bit counter, symbol counter and symbol accumulator clear to 0.
  - All outputs are 0.
- States are HUNT and LOCK. All outputs are registered.
- Cycles with bit_en_sig=0: no state change. Strobes (symbol_valid, frame_start, frame_end, sync_hit) are 0. symbol_sig holds its last value.
- HUNT:
  - On bit_en_sig=1, shift serial_sig into the LSB of the sync register.
  - The fill counter increments, saturating at SYNC_LEN.
  - Candidate window = {sync_reg[SYNC_LEN-2:0], serial_sig}.
  - Sync hit condition: fill counter >= SYNC_LEN-1 before this bit (i.e. the window holds SYNC_LEN fresh bits) AND popcount(window XOR SYNC_WORD) <= MAX_ERR.
  - On a hit, in the next cycle: sync_hit_sig=1, locked_sig=1, state=LOCK, bit and symbol counters=0.
- LOCK:
  - Each bit_en_sig=1 shifts serial_sig into the symbol accumulator; the bit counter increments.
  - On the WIDTH-th bit, in the next cycle:
    - symbol_sig = {accumulator[WIDTH-2:0], serial_sig}
    - symbol_valid_sig = 1
    - bit counter = 0
    - symbol counter increments
  - Latency is one clock from the bit_en cycle of the symbol's last bit.
  - frame_start_sig accompanies symbol index 0; frame_end_sig accompanies index FRAME_SYMS-1. When FRAME_SYMS=1, both are asserted together.
  - After the last symbol, in the same cycle that frame_end_sig is asserted: locked_sig=0, state=HUNT, fill counter=0, sync register=0.
  - Bits received during LOCK never count toward the next sync search; a fresh SYNC_LEN bits are required.
- flush_sig=1: synchronous abort in any state.
  - Next cycle: state=HUNT; all counters, fill and accumulator cleared; locked_sig=0; no strobes.
  - flush_sig has priority over a concurrent bit_en_sig, and that bit is discarded.
  - A partially accumulated symbol is dropped and never emitted.
- Sync search stops in LOCK: a sync pattern inside frame data is ignored.
- Counter widths: symbol counter $clog2(FRAME_SYMS+1); bit counter $clog2(WIDTH+1); fill counter $clog2(SYNC_LEN+1). Popcount is sized for SYNC_LEN with no overflow.
- Reset asserted mid-frame aborts immediately. No strobe is generated on reset release.

Test Plan:
Parameters for all scenarios unless stated: WIDTH=2, SYNC_WORD=8'hB8, FRAME_SYMS=4, MAX_ERR=0.
1. Reset: assert reset_sig with the clock stopped -> all outputs 0 without any clock edge. Release, then drive idle bits -> no strobes.
2. Continuous bit_en, bits 1,0,1,1,1,0,0,0 then 1,1,0,1,1,0,0,0:
   - sync_hit_sig pulses the cycle after the 8th bit; locked_sig rises in the same cycle.
   - symbols 2'b11, 2'b01, 2'b10, 2'b00 appear, each one cycle after its 2nd bit.
   - frame_start accompanies 2'b11; frame_end accompanies 2'b00; locked_sig falls with frame_end.
3. Same stream with bit_en_sig toggling 1,0,1,0 -> identical symbol values and order; each strobe lags its completing bit by exactly one cycle.
4. Sync 8'hB9 (one bit error):
   - MAX_ERR=0 -> no sync_hit.
   - MAX_ERR=1 -> sync_hit plus 4 symbols.
   - 8'hBB (two errors) with MAX_ERR=1 -> no hit.
5. Flush: after sync plus one bit of the 2nd symbol, assert flush_sig together with bit_en_sig -> only the 1st symbol is emitted; locked_sig=0 next cycle. A re-sent sync is detected after 8 new bits.
6. Re-hunt freshness: frame ends and the last 4 frame bits plus the next 4 bits form 8'hB8 -> no hit. The full 8'hB8 sent after the frame is detected. Async reset mid-frame -> outputs clear at once.

Source files
------------

// File: rtl/conv_symbol_framer.sv
// Sync-word hunter and code-symbol framer for the serial bit stream feeding the Viterbi decoder.
// Tolerates up to MAX_ERR bit errors in the sync word, then emits FRAME_SYMS WIDTH-bit symbols and re-hunts.
module conv_symbol_framer #(
  parameter int                    WIDTH      = 2,
  parameter int                    SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0]   SYNC_WORD  = 8'hB8,
  parameter int                    FRAME_SYMS = 16,
  parameter int                    MAX_ERR    = 0
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             serial_sig,
  input  logic             bit_en_sig,
  input  logic             flush_sig,
  output logic [WIDTH-1:0] symbol_sig,
  output logic             symbol_valid_sig,
  output logic             frame_start_sig,
  output logic             frame_end_sig,
  output logic             sync_hit_sig,
  output logic             locked_sig
);

  localparam int SW = $clog2(FRAME_SYMS + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int FW = $clog2(SYNC_LEN + 1);

  localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_LEN);
  localparam logic [FW-1:0] FILL_MIN  = FW'(SYNC_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(FRAME_SYMS - 1);
  localparam logic [FW-1:0] ERR_LIM   = FW'(MAX_ERR);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t              state, state_n;
  logic [SYNC_LEN-1:0] sync_reg, sync_n;
  logic [FW-1:0]       fill_cnt, fill_n;
  logic [BW-1:0]       bit_cnt, bit_n;
  logic [SW-1:0]       sym_cnt, sym_n;
  logic [WIDTH-1:0]    acc, acc_n;
  logic [WIDTH-1:0]    symbol_n;
  logic                valid_n, start_n, end_n, hit_n, locked_n;

  logic [SYNC_LEN-1:0] window, diff;
  logic [FW-1:0]       err_cnt;

  assign window = {sync_reg[SYNC_LEN-2:0], serial_sig};
  assign diff   = window ^ SYNC_WORD;

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < SYNC_LEN; i++) err_cnt = err_cnt + FW'(diff[i]);
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state            <= HUNT;
      sync_reg         <= '0;
      fill_cnt         <= '0;
      bit_cnt          <= '0;
      sym_cnt          <= '0;
      acc              <= '0;
      symbol_sig       <= '0;
      symbol_valid_sig <= 1'b0;
      frame_start_sig  <= 1'b0;
      frame_end_sig    <= 1'b0;
      sync_hit_sig     <= 1'b0;
      locked_sig       <= 1'b0;
    end else begin
      state            <= state_n;
      sync_reg         <= sync_n;
      fill_cnt         <= fill_n;
      bit_cnt          <= bit_n;
      sym_cnt          <= sym_n;
      acc              <= acc_n;
      symbol_sig       <= symbol_n;
      symbol_valid_sig <= valid_n;
      frame_start_sig  <= start_n;
      frame_end_sig    <= end_n;
      sync_hit_sig     <= hit_n;
      locked_sig       <= locked_n;
    end
  end

  always_comb begin
    state_n  = state;
    sync_n   = sync_reg;
    fill_n   = fill_cnt;
    bit_n    = bit_cnt;
    sym_n    = sym_cnt;
    acc_n    = acc;
    symbol_n = symbol_sig;
    valid_n  = 1'b0;
    start_n  = 1'b0;
    end_n    = 1'b0;
    hit_n    = 1'b0;
    locked_n = locked_sig;

    if (flush_sig) begin
      state_n  = HUNT;
      sync_n   = '0;
      fill_n   = '0;
      bit_n    = '0;
      sym_n    = '0;
      acc_n    = '0;
      locked_n = 1'b0;
    end else if (bit_en_sig) begin
      case (state)
        HUNT: begin
          sync_n = window;
          if (fill_cnt != FILL_FULL) fill_n = fill_cnt + FW'(1);
          if (fill_cnt >= FILL_MIN && err_cnt <= ERR_LIM) begin
            state_n  = LOCK;
            hit_n    = 1'b1;
            locked_n = 1'b1;
            bit_n    = '0;
            sym_n    = '0;
          end
        end
        LOCK: begin
          acc_n = {acc[WIDTH-2:0], serial_sig};
          if (bit_cnt == BIT_LAST) begin
            symbol_n = {acc[WIDTH-2:0], serial_sig};
            valid_n  = 1'b1;
            start_n  = (sym_cnt == '0);
            bit_n    = '0;
            sym_n    = sym_cnt + SW'(1);
            // Frame complete: the hunt restarts from an empty window so frame bits never seed a sync.
            if (sym_cnt == SYM_LAST) begin
              end_n    = 1'b1;
              locked_n = 1'b0;
              state_n  = HUNT;
              fill_n   = '0;
              sync_n   = '0;
              sym_n    = '0;
            end
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_symbol_framer.sv
// Bench for conv_symbol_framer: vector table, directed corner sequences and randomized traffic
// checked against a queue-based reference model, on MAX_ERR=0 and MAX_ERR=1 instances.
module tb_conv_symbol_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser = 1'b0;
  logic       en  = 1'b0;
  logic       fl  = 1'b0;
  bit         run = 1'b0;

  logic [1:0] sym_a, sym_b;
  logic       va, vb, fsa, fsb, fea, feb, ha, hb, la, lb;

  conv_symbol_framer #(.WIDTH(2), .SYNC_LEN(8), .SYNC_WORD(8'hB8), .FRAME_SYMS(4), .MAX_ERR(0)) dut_a (
    .clk_sig(clk), .reset_sig(rst), .serial_sig(ser), .bit_en_sig(en), .flush_sig(fl),
    .symbol_sig(sym_a), .symbol_valid_sig(va), .frame_start_sig(fsa), .frame_end_sig(fea),
    .sync_hit_sig(ha), .locked_sig(la));

  conv_symbol_framer #(.WIDTH(2), .SYNC_LEN(8), .SYNC_WORD(8'hB8), .FRAME_SYMS(4), .MAX_ERR(1)) dut_b (
    .clk_sig(clk), .reset_sig(rst), .serial_sig(ser), .bit_en_sig(en), .flush_sig(fl),
    .symbol_sig(sym_b), .symbol_valid_sig(vb), .frame_start_sig(fsb), .frame_end_sig(feb),
    .sync_hit_sig(hb), .locked_sig(lb));

  initial forever begin
    #5;
    if (run) clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output vector layout: {symbol[1:0], valid, frame_start, frame_end, sync_hit, locked}
  function automatic logic [6:0] out_a();
    return {sym_a, va, fsa, fea, ha, la};
  endfunction
  function automatic logic [6:0] out_b();
    return {sym_b, vb, fsb, feb, hb, lb};
  endfunction

  // Reference model: index k is the instance whose MAX_ERR equals k.
  bit         hq[2][$];
  bit         sq[2][$];
  bit         mlock[2];
  int         midx[2];
  logic [1:0] e_sym[2];
  logic [3:0] e_str[2];
  bit         e_lk[2];

  function automatic logic [6:0] exp_v(input int k);
    return {e_sym[k], e_str[k], e_lk[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hq[k].delete();
      sq[k].delete();
      mlock[k] = 1'b0;
      midx[k]  = 0;
      e_sym[k] = 2'b00;
      e_str[k] = 4'b0000;
      e_lk[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit f, input bit e, input bit s);
    logic [7:0] sw;
    int errs;
    sw = 8'hB8;
    for (int k = 0; k < 2; k++) begin
      e_str[k] = 4'b0000;
      if (f) begin
        hq[k].delete();
        sq[k].delete();
        mlock[k] = 1'b0;
        midx[k]  = 0;
        e_lk[k]  = 1'b0;
      end else if (e) begin
        if (!mlock[k]) begin
          hq[k].push_back(s);
          if (hq[k].size() > 8) void'(hq[k].pop_front());
          if (hq[k].size() == 8) begin
            errs = 0;
            for (int i = 0; i < 8; i++) if (hq[k][i] != sw[7-i]) errs++;
            if (errs <= k) begin
              e_str[k] = 4'b0001;
              e_lk[k]  = 1'b1;
              mlock[k] = 1'b1;
              hq[k].delete();
              sq[k].delete();
              midx[k]  = 0;
            end
          end
        end else begin
          sq[k].push_back(s);
          if (sq[k].size() == 2) begin
            e_sym[k] = {sq[k][0], sq[k][1]};
            sq[k].delete();
            e_str[k] = {1'b1, midx[k] == 0, midx[k] == 3, 1'b0};
            midx[k]++;
            if (midx[k] == 4) begin
              mlock[k] = 1'b0;
              e_lk[k]  = 1'b0;
              midx[k]  = 0;
            end
          end
        end
      end
    end
  endtask

  int         hits_a, hits_b, vals_a, vals_b;
  logic [1:0] syms_a[$];

  task automatic clr_counts();
    hits_a = 0; hits_b = 0; vals_a = 0; vals_b = 0;
    syms_a.delete();
  endtask

  task automatic cyc(input bit f, input bit e, input bit s);
    fl = f; en = e; ser = s;
    @(posedge clk);
    model_step(f, e, s);
    #1;
    chk("out_a", {25'd0, out_a()}, {25'd0, exp_v(0)});
    chk("out_b", {25'd0, out_b()}, {25'd0, exp_v(1)});
    hits_a += int'(ha); hits_b += int'(hb);
    vals_a += int'(va); vals_b += int'(vb);
    if (va) syms_a.push_back(sym_a);
    fl = 1'b0; en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b1, b[i]);
      if (gap) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    bit         f;
    bit         e;
    bit         s;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit f, input bit e, input bit s, input logic [6:0] exp);
    vec_t v;
    v.f = f; v.e = e; v.s = s; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    // Continuous stream: sync B8 then data 11 01 10 00 (expected outputs of the MAX_ERR=0 instance)
    add(0, 0, 1, 7'b0000000);
    add(0, 0, 0, 7'b0000000);
    add(0, 0, 1, 7'b0000000);
    add(0, 1, 1, 7'b0000000);
    add(0, 1, 0, 7'b0000000);
    add(0, 1, 1, 7'b0000000);
    add(0, 1, 1, 7'b0000000);
    add(0, 1, 1, 7'b0000000);
    add(0, 1, 0, 7'b0000000);
    add(0, 1, 0, 7'b0000000);
    add(0, 1, 0, 7'b0000011);
    add(0, 1, 1, 7'b0000001);
    add(0, 1, 1, 7'b1111001);
    add(0, 1, 0, 7'b1100001);
    add(0, 1, 1, 7'b0110001);
    add(0, 1, 1, 7'b0100001);
    add(0, 1, 0, 7'b1010001);
    add(0, 1, 0, 7'b1000001);
    add(0, 1, 0, 7'b0010100);
    add(0, 0, 1, 7'b0000000);

    // Reset with the clock stopped
    #2 rst = 1'b1;
    #1;
    chk("rst_a", {25'd0, out_a()}, 32'd0);
    chk("rst_b", {25'd0, out_b()}, 32'd0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clr_counts();
    repeat (3) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));

    foreach (tbl[i]) begin
      fl = tbl[i].f; en = tbl[i].e; ser = tbl[i].s;
      @(posedge clk);
      model_step(tbl[i].f, tbl[i].e, tbl[i].s);
      #1;
      chk($sformatf("tbl%0d", i), {25'd0, out_a()}, {25'd0, tbl[i].exp});
      chk($sformatf("tbl%0d_b", i), {25'd0, out_b()}, {25'd0, exp_v(1)});
      fl = 1'b0; en = 1'b0;
    end

    // Gapped bit_en: same stream, same symbols
    clr_counts();
    send_byte(8'hB8, 1'b1);
    send_byte(8'b11011000, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gap_nsym", syms_a.size(), 32'd4);
    if (syms_a.size() == 4)
      chk("gap_syms", {24'd0, syms_a[0], syms_a[1], syms_a[2], syms_a[3]}, 32'h000000D8);

    // One-bit-error sync word
    cyc(1'b1, 1'b0, 1'b0);
    clr_counts();
    send_byte(8'hB9, 1'b0);
    send_byte(8'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("b9_hits_a", hits_a, 32'd0);
    chk("b9_hits_b", hits_b, 32'd1);
    chk("b9_syms_b", vals_b, 32'd4);

    // Two-bit-error sync word
    cyc(1'b1, 1'b0, 1'b0);
    clr_counts();
    send_byte(8'hBB, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("bb_hits_a", hits_a, 32'd0);
    chk("bb_hits_b", hits_b, 32'd0);

    // Flush with a concurrent bit, mid-symbol
    cyc(1'b1, 1'b0, 1'b0);
    clr_counts();
    send_byte(8'hB8, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("flush_locked", {31'd0, la}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("flush_nsym", vals_a, 32'd1);
    clr_counts();
    send_byte(8'hB8, 1'b0);
    chk("resync_hit", hits_a, 32'd1);
    send_byte(8'h00, 1'b0);

    // Re-hunt freshness: frame tail 1011 plus 1000 must not sync
    cyc(1'b1, 1'b0, 1'b0);
    send_byte(8'hB8, 1'b0);
    send_byte(8'b00001011, 1'b0);
    clr_counts();
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("fresh_nohit", hits_a, 32'd0);
    send_byte(8'hB8, 1'b0);
    chk("fresh_hit", hits_a, 32'd1);

    // Asynchronous reset mid-frame
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_a", {25'd0, out_a()}, 32'd0);
    chk("arst_b", {25'd0, out_b()}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);

    // Randomized traffic with frequent (possibly corrupted) sync words
    begin
      bit         src[$];
      logic [7:0] b;
      logic [7:0] one;
      bit         f, e, s;
      int         r;
      one = 8'd1;
      repeat (3000) begin
        if (src.size() == 0) begin
          r = int'($urandom_range(0, 2));
          if (r == 0)      b = 8'hB8;
          else if (r == 1) b = 8'hB8 ^ (one << $urandom_range(0, 7));
          else             b = 8'($urandom);
          for (int i = 7; i >= 0; i--) src.push_back(b[i]);
        end
        f = ($urandom_range(0, 99) == 0);
        e = 1'($urandom_range(0, 1));
        if (e && !f) s = src.pop_front();
        else         s = 1'($urandom_range(0, 1));
        cyc(f, e, s);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
